// File: rtl/blit_cmd_queue_if.sv
// blit_cmd_queue_if
//   Command handshake bundle between the register block (producer),
//   the command queue and the blitter engine (consumer).
//   Signals:
//     in_cmd    : command word pushed by the register block
//     in_valid  : single-cycle push strobe, no back-pressure
//     out_cmd   : head command presented to the blitter
//     out_valid : head entry present
//     out_ready : blitter accepts the head entry
//   Modports:
//     master : bench / surrounding logic side (drives push and ready)
//     slave  : queue side (consumes push and ready, drives head)
interface blit_cmd_queue_if #(
    parameter int WIDTH = 96
) ();
    logic [WIDTH-1:0] in_cmd;
    logic             in_valid;
    logic [WIDTH-1:0] out_cmd;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_cmd,
        output in_valid,
        output out_ready,
        input  out_cmd,
        input  out_valid
    );

    modport slave (
        input  in_cmd,
        input  in_valid,
        input  out_ready,
        output out_cmd,
        output out_valid
    );
endinterface

// File: rtl/blit_cmd_queue.sv
// blit_cmd_queue
//   Command FIFO between the hardware-register block and the blitter.
//   A DEPTH x WIDTH synchronous-read RAM feeds an output register that
//   presents the head entry first-word-fall-through. The output register
//   counts toward occupancy, so total capacity is exactly DEPTH.
//   Ports:
//     clock          : system clock, posedge
//     reset          : synchronous, active-high
//     bus            : handshake bundle (slave modport)
//     flush          : synchronous discard of all entries
//     clear_overflow : clears the sticky overflow flag
//     slots_free     : DEPTH minus occupancy, registered
//     overflow       : sticky, set when a push is dropped on a full queue
//     empty          : occupancy == 0, registered with slots_free
module blit_cmd_queue #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 96,
    parameter int ABITS = 8
) (
    input  logic            clock,
    input  logic            reset,
    blit_cmd_queue_if.slave bus,
    input  logic            flush,
    input  logic            clear_overflow,
    output logic [ABITS:0]  slots_free,
    output logic            overflow,
    output logic            empty
);
    localparam logic [ABITS:0] FULL_CNT = DEPTH[ABITS:0];

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [ABITS-1:0] r_wr_ptr;
    logic [ABITS-1:0] r_rd_ptr;
    logic [ABITS:0]   r_occ;
    logic [ABITS:0]   r_slots_free;
    logic             r_empty;
    logic             r_overflow;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_cmd;

    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic [ABITS:0]   w_ram_cnt;
    logic             w_load;
    logic [ABITS:0]   w_occ_next;

    // Push/drop decisions use pre-edge occupancy, so a pop in the same
    // cycle never rescues a push into a full queue.
    assign w_full = (r_occ == FULL_CNT);
    assign w_push = bus.in_valid && !w_full;
    assign w_drop = bus.in_valid && w_full;
    assign w_pop  = r_out_valid && bus.out_ready;

    // Entries still held in the RAM (not yet in the output register).
    // With the output register empty this is at most one, so the read
    // and write pointers never collide while w_load is active.
    assign w_ram_cnt = r_occ - {{ABITS{1'b0}}, r_out_valid};
    assign w_load    = (w_ram_cnt != '0) && (!r_out_valid || w_pop);

    always_comb begin
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + {{ABITS{1'b0}}, 1'b1};
            2'b01:   w_occ_next = r_occ - {{ABITS{1'b0}}, 1'b1};
            default: w_occ_next = r_occ;
        endcase
    end

    // RAM write port; contents are not reset.
    always_ff @(posedge clock) begin
        if (!reset && !flush && w_push) begin
            r_mem[r_wr_ptr] <= bus.in_cmd;
        end
    end

    // Pointers, occupancy, output register and registered status.
    // The RAM read register doubles as the output register: it only
    // loads when empty or being popped, which keeps out_cmd stable
    // while the blitter stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_slots_free <= FULL_CNT;
            r_empty      <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_cmd    <= '0;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_slots_free <= FULL_CNT;
            r_empty      <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ABITS'(1);
            end
            if (w_load) begin
                r_out_cmd   <= r_mem[r_rd_ptr];
                r_rd_ptr    <= r_rd_ptr + ABITS'(1);
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            r_occ        <= w_occ_next;
            r_slots_free <= FULL_CNT - w_occ_next;
            r_empty      <= (w_occ_next == '0);
        end
    end

    // A dropped push outranks a simultaneous clear; flush leaves the
    // flag alone and ignores the push it overrides.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop && !flush) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.out_cmd   = r_out_cmd;
    assign bus.out_valid = r_out_valid;
    assign slots_free    = r_slots_free;
    assign overflow      = r_overflow;
    assign empty         = r_empty;
endmodule

// File: tb/tb_blit_cmd_queue.sv
// tb_blit_cmd_queue
//   Scoreboard bench for blit_cmd_queue: every accepted push is queued
//   as expected output, every pop is compared against the queue head,
//   and an independent occupancy/overflow model predicts the status
//   outputs after each clock.
module tb_blit_cmd_queue;
    logic       clock;
    logic       reset;
    logic       flush;
    logic       clear_overflow;
    logic [8:0] slots_free;
    logic       overflow;
    logic       empty;

    blit_cmd_queue_if #(.WIDTH(96)) bus ();

    blit_cmd_queue #(
        .DEPTH(256),
        .WIDTH(96),
        .ABITS(8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .slots_free     (slots_free),
        .overflow       (overflow),
        .empty          (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int m_occ    = 0;
    int m_ovf    = 0;
    int n_pops   = 0;
    int gap      = 0;
    logic [95:0] sb [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One clock of stimulus with model update and post-edge checks.
    task automatic step(input logic iv, input logic [95:0] cmd, input logic rdy,
                        input logic fl, input logic clr);
        logic pop;
        logic push;
        logic drop;
        logic [95:0] exp;
        bus.in_valid   = iv;
        bus.in_cmd     = cmd;
        bus.out_ready  = rdy;
        flush          = fl;
        clear_overflow = clr;
        pop  = bus.out_valid && rdy && !fl;
        push = iv && !fl && (m_occ < 256);
        drop = iv && !fl && (m_occ == 256);
        if (pop) begin
            n_pops++;
            if (sb.size() == 0) begin
                check("pop_without_entry", 128'(1), 128'(0));
            end else begin
                exp = sb.pop_front();
                check("pop_cmd", 128'(bus.out_cmd), 128'(exp));
            end
        end
        if (fl) begin
            sb.delete();
            m_occ = 0;
        end else begin
            if (push) sb.push_back(cmd);
            m_occ = m_occ + (push ? 1 : 0) - (pop ? 1 : 0);
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        tick();
        bus.in_valid   = 1'b0;
        flush          = 1'b0;
        clear_overflow = 1'b0;
        check("slots_free", 128'(slots_free), 128'(256 - m_occ));
        check("empty", 128'(empty), 128'(m_occ == 0));
        check("overflow", 128'(overflow), 128'(m_ovf));
        check("valid_without_data", 128'(bus.out_valid && (m_occ == 0)), 128'(0));
        if (bus.out_valid && sb.size() > 0) begin
            check("head_cmd", 128'(bus.out_cmd), 128'(sb[0]));
        end
        if (m_occ > 0 && !bus.out_valid) gap++;
        else gap = 0;
        check("valid_gap_le1", 128'(gap <= 1), 128'(1));
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        flush          = 1'b0;
        clear_overflow = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        m_occ = 0;
        m_ovf = 0;
        gap   = 0;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_cmd", 128'(bus.out_cmd), 128'(0));
        check("rst_slots_free", 128'(slots_free), 128'(256));
        check("rst_overflow", 128'(overflow), 128'(0));
        check("rst_empty", 128'(empty), 128'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && m_occ > 0; k++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [95:0] c;
        reset         = 1'b1;
        bus.in_cmd    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        clear_overflow = 1'b0;
        do_reset();

        // Latency from push into an empty queue.
        step(1'b1, 96'h1, 1'b0, 1'b0, 1'b0);
        check("lat_n1_valid", 128'(bus.out_valid), 128'(0));
        check("lat_n1_slots", 128'(slots_free), 128'(255));
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("lat_n2_valid", 128'(bus.out_valid), 128'(1));
        check("lat_n2_cmd", 128'(bus.out_cmd), 128'(1));
        drain();

        // Fill to capacity with ready low.
        for (int i = 0; i < 256; i++) begin
            w = 32'(i);
            step(1'b1, {w, ~w, w + 32'd1}, 1'b0, 1'b0, 1'b0);
        end
        check("fill_slots", 128'(slots_free), 128'(0));
        check("fill_overflow", 128'(overflow), 128'(0));

        // Dropped push when full, then clear.
        step(1'b1, 96'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 128'(overflow), 128'(1));
        check("ovf_slots", 128'(slots_free), 128'(0));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("ovf_clear", 128'(overflow), 128'(0));

        // Drain must yield exactly the original 256.
        n_pops = 0;
        drain();
        check("drain_count", 128'(n_pops), 128'(256));
        check("drain_empty", 128'(empty), 128'(1));
        check("drain_slots", 128'(slots_free), 128'(256));

        // Simultaneous push/pop at 256 and 255.
        for (int i = 0; i < 256; i++) step(1'b1, {$urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        step(1'b1, 96'hBAD, 1'b1, 1'b0, 1'b0);
        check("pp256_slots", 128'(slots_free), 128'(1));
        check("pp256_ovf", 128'(overflow), 128'(1));
        step(1'b1, 96'h255, 1'b1, 1'b0, 1'b0);
        check("pp255_slots", 128'(slots_free), 128'(1));

        // Reset mid-operation clears contents and overflow.
        do_reset();

        // Simultaneous push/pop at occupancy 1.
        step(1'b1, 96'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 96'hA2, 1'b1, 1'b0, 1'b0);
        check("pp1_slots", 128'(slots_free), 128'(255));
        drain();

        // Flush with a simultaneous push, then a clean push.
        for (int i = 0; i < 10; i++) step(1'b1, 96'(i + 100), 1'b0, 1'b0, 1'b0);
        step(1'b1, 96'hF00, 1'b1, 1'b1, 1'b0);
        check("flush_slots", 128'(slots_free), 128'(256));
        check("flush_valid", 128'(bus.out_valid), 128'(0));
        step(1'b1, 96'hABC, 1'b0, 1'b0, 1'b0);
        check("postflush_n1_valid", 128'(bus.out_valid), 128'(0));
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("postflush_n2_valid", 128'(bus.out_valid), 128'(1));
        check("postflush_n2_cmd", 128'(bus.out_cmd), 128'(96'hABC));
        drain();

        // Random soak: moderate load, then a heavier phase for many wraps.
        for (int k = 0; k < 20000; k++) begin
            c = {$urandom, $urandom, $urandom};
            step(($urandom_range(9) < 4), c, ($urandom_range(1) == 1), 1'b0, 1'b0);
        end
        for (int k = 0; k < 25000; k++) begin
            c = {$urandom, $urandom, $urandom};
            step(($urandom_range(9) < 8), c, ($urandom_range(9) < 9), 1'b0,
                 ($urandom_range(63) == 0));
        end
        drain();
        check("final_empty", 128'(empty), 128'(1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
